// File: rtl/sap_ctrl_pkg.sv
// ============================================================================
// sap_ctrl_pkg : shared encodings for the SAP microcoded control sequencer
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package sap_ctrl_pkg;

  localparam int c_opcode_w = 4;
  localparam int c_step_w   = 3;

  typedef logic [c_opcode_w-1:0] opcode_t;
  typedef logic [c_step_w-1:0]   step_t;

  localparam opcode_t c_op_nop = 4'd0;
  localparam opcode_t c_op_lda = 4'd1;
  localparam opcode_t c_op_add = 4'd2;
  localparam opcode_t c_op_sub = 4'd3;
  localparam opcode_t c_op_sta = 4'd4;
  localparam opcode_t c_op_ldi = 4'd5;
  localparam opcode_t c_op_jmp = 4'd6;
  localparam opcode_t c_op_jc  = 4'd7;
  localparam opcode_t c_op_jz  = 4'd8;
  localparam opcode_t c_op_and = 4'd9;
  localparam opcode_t c_op_or  = 4'd10;
  localparam opcode_t c_op_out = 4'd14;
  localparam opcode_t c_op_hlt = 4'd15;

  localparam step_t c_t0 = 3'd0;
  localparam step_t c_t1 = 3'd1;
  localparam step_t c_t2 = 3'd2;
  localparam step_t c_t3 = 3'd3;
  localparam step_t c_t4 = 3'd4;

  localparam int c_flag_carry = 0;
  localparam int c_flag_zero  = 1;

  typedef enum logic [1:0] {
    c_alu_add = 2'd0,
    c_alu_sub = 2'd1,
    c_alu_and = 2'd2,
    c_alu_or  = 2'd3
  } alu_op_t;

  typedef struct packed {
    logic    pc_out;
    logic    pc_inc;
    logic    pc_load;
    logic    mar_in;
    logic    ram_out;
    logic    ram_in;
    logic    ir_in;
    logic    ir_out;
    logic    a_in;
    logic    a_out;
    logic    b_in;
    logic    alu_out;
    alu_op_t operation;
    logic    flags_in;
    logic    out_in;
    logic    halt;
  } ctrl_word_t;

  function automatic logic is_alu_op(input opcode_t op);
    return (op == c_op_add) || (op == c_op_sub) || (op == c_op_and) || (op == c_op_or);
  endfunction

  function automatic alu_op_t alu_op_of(input opcode_t op);
    alu_op_t r;
    case (op)
      c_op_sub: r = c_alu_sub;
      c_op_and: r = c_alu_and;
      c_op_or:  r = c_alu_or;
      default:  r = c_alu_add;
    endcase
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/control_sequencer_if.sv
// ============================================================================
// control_sequencer_if : opcode/flags in, control word out, for the SAP sequencer
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface control_sequencer_if #(
  parameter int OPCODE_W = 4,
  parameter int STEP_W   = 3
);

  logic [OPCODE_W-1:0] InstrOpcode;
  logic [1:0]          Flags;
  logic [STEP_W-1:0]   Step;
  logic                PCOut;
  logic                PCInc;
  logic                PCLoad;
  logic                MARIn;
  logic                RAMOut;
  logic                RAMIn;
  logic                IRIn;
  logic                IROut;
  logic                AIn;
  logic                AOut;
  logic                BIn;
  logic                ALUOut;
  logic [1:0]          Operation;
  logic                FlagsIn;
  logic                OutIn;
  logic                Halt;

  modport master (
    input  InstrOpcode, Flags,
    output Step, PCOut, PCInc, PCLoad, MARIn, RAMOut, RAMIn, IRIn, IROut,
           AIn, AOut, BIn, ALUOut, Operation, FlagsIn, OutIn, Halt
  );

  modport slave (
    output InstrOpcode, Flags,
    input  Step, PCOut, PCInc, PCLoad, MARIn, RAMOut, RAMIn, IRIn, IROut,
           AIn, AOut, BIn, ALUOut, Operation, FlagsIn, OutIn, Halt
  );

endinterface

`default_nettype wire

// File: rtl/sap_step_counter.sv
// ============================================================================
// sap_step_counter : T-state counter with last-step clear and halt hold
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module sap_step_counter
  import sap_ctrl_pkg::*;
#(
  parameter int STEP_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr,
  input  logic              i_hold,
  output logic [STEP_W-1:0] o_step
);

  localparam logic [STEP_W-1:0] c_last_step = STEP_W'(c_t4);

  logic [STEP_W-1:0] r_step;

  // Anything at or past T4 wraps, so unreachable codes recover in one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_step <= '0;
    end else if (i_hold) begin
      r_step <= r_step;
    end else if (i_clr || (r_step >= c_last_step)) begin
      r_step <= '0;
    end else begin
      r_step <= r_step + STEP_W'(1);
    end
  end

  assign o_step = r_step;

endmodule

`default_nettype wire

// File: rtl/control_sequencer.sv
// ============================================================================
// control_sequencer : microcoded fetch/execute control unit for the SAP datapath
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module control_sequencer
  import sap_ctrl_pkg::*;
#(
  parameter int OPCODE_W = c_opcode_w,
  parameter int STEP_W   = c_step_w
) (
  input  logic                Clock,
  input  logic                ResetN,
  control_sequencer_if.master bus
);

  logic [OPCODE_W-1:0] w_opcode_raw;
  opcode_t             w_opcode;
  logic [STEP_W-1:0]   w_step;
  logic                r_halted;
  logic                w_last;
  logic                w_halt_now;
  logic                w_hold;
  ctrl_word_t          w_word;

  assign w_opcode_raw = bus.InstrOpcode;
  assign w_opcode     = opcode_t'(w_opcode_raw);

  sap_step_counter #(
    .STEP_W (STEP_W)
  ) u_step_counter (
    .clk    (Clock),
    .rst_n  (ResetN),
    .i_clr  (w_last),
    .i_hold (w_hold),
    .o_step (w_step)
  );

  // State register: the sticky halted flag (step lives in the counter).
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      r_halted <= 1'b0;
    end else if (w_halt_now) begin
      r_halted <= 1'b1;
    end
  end

  // Next-state decode: which step ends the instruction, and halt entry.
  always_comb begin
    w_last     = 1'b0;
    w_halt_now = 1'b0;
    if (!r_halted) begin
      case (w_step)
        c_t2: begin
          if (w_opcode == c_op_hlt) begin
            w_halt_now = 1'b1;
          end else if (!(is_alu_op(w_opcode) || (w_opcode == c_op_lda) ||
                         (w_opcode == c_op_sta))) begin
            w_last = 1'b1;
          end
        end
        c_t3:    w_last = (w_opcode == c_op_lda) || (w_opcode == c_op_sta);
        c_t4:    w_last = is_alu_op(w_opcode);
        default: w_last = 1'b0;
      endcase
    end
  end

  assign w_hold = r_halted | w_halt_now;

  // Output decode: microcode control word; held at zero throughout reset.
  always_comb begin
    w_word = '0;
    if (ResetN) begin
      if (r_halted) begin
        w_word.halt = 1'b1;
      end else begin
        case (w_step)
          c_t0: begin
            w_word.pc_out = 1'b1;
            w_word.mar_in = 1'b1;
          end
          c_t1: begin
            w_word.ram_out = 1'b1;
            w_word.ir_in   = 1'b1;
            w_word.pc_inc  = 1'b1;
          end
          c_t2: begin
            case (w_opcode)
              c_op_lda, c_op_add, c_op_sub, c_op_and, c_op_or, c_op_sta: begin
                w_word.ir_out = 1'b1;
                w_word.mar_in = 1'b1;
              end
              c_op_ldi: begin
                w_word.ir_out = 1'b1;
                w_word.a_in   = 1'b1;
              end
              c_op_jmp: begin
                w_word.ir_out  = 1'b1;
                w_word.pc_load = 1'b1;
              end
              c_op_jc: begin
                w_word.ir_out  = bus.Flags[c_flag_carry];
                w_word.pc_load = bus.Flags[c_flag_carry];
              end
              c_op_jz: begin
                w_word.ir_out  = bus.Flags[c_flag_zero];
                w_word.pc_load = bus.Flags[c_flag_zero];
              end
              c_op_out: begin
                w_word.a_out  = 1'b1;
                w_word.out_in = 1'b1;
              end
              c_op_hlt: w_word.halt = 1'b1;
              default:  w_word.halt = 1'b0;
            endcase
          end
          c_t3: begin
            if (w_opcode == c_op_lda) begin
              w_word.ram_out = 1'b1;
              w_word.a_in    = 1'b1;
            end else if (is_alu_op(w_opcode)) begin
              w_word.ram_out = 1'b1;
              w_word.b_in    = 1'b1;
            end else if (w_opcode == c_op_sta) begin
              w_word.a_out  = 1'b1;
              w_word.ram_in = 1'b1;
            end
          end
          c_t4: begin
            if (is_alu_op(w_opcode)) begin
              w_word.alu_out   = 1'b1;
              w_word.a_in      = 1'b1;
              w_word.flags_in  = 1'b1;
              w_word.operation = alu_op_of(w_opcode);
            end
          end
          default: w_word.halt = 1'b0;
        endcase
      end
    end
  end

  assign bus.Step      = w_step;
  assign bus.PCOut     = w_word.pc_out;
  assign bus.PCInc     = w_word.pc_inc;
  assign bus.PCLoad    = w_word.pc_load;
  assign bus.MARIn     = w_word.mar_in;
  assign bus.RAMOut    = w_word.ram_out;
  assign bus.RAMIn     = w_word.ram_in;
  assign bus.IRIn      = w_word.ir_in;
  assign bus.IROut     = w_word.ir_out;
  assign bus.AIn       = w_word.a_in;
  assign bus.AOut      = w_word.a_out;
  assign bus.BIn       = w_word.b_in;
  assign bus.ALUOut    = w_word.alu_out;
  assign bus.Operation = w_word.operation;
  assign bus.FlagsIn   = w_word.flags_in;
  assign bus.OutIn     = w_word.out_in;
  assign bus.Halt      = w_word.halt;

endmodule

`default_nettype wire

// File: tb/tb_control_sequencer.sv
// ============================================================================
// tb_control_sequencer : vector table, corner sequences and random stream vs model
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_control_sequencer;

  localparam logic [16:0] c_halt    = 17'h00001;
  localparam logic [16:0] c_outin   = 17'h00002;
  localparam logic [16:0] c_flagsin = 17'h00004;
  localparam logic [16:0] c_aluout  = 17'h00020;
  localparam logic [16:0] c_bin     = 17'h00040;
  localparam logic [16:0] c_aout    = 17'h00080;
  localparam logic [16:0] c_ain     = 17'h00100;
  localparam logic [16:0] c_irout   = 17'h00200;
  localparam logic [16:0] c_irin    = 17'h00400;
  localparam logic [16:0] c_ramin   = 17'h00800;
  localparam logic [16:0] c_ramout  = 17'h01000;
  localparam logic [16:0] c_marin   = 17'h02000;
  localparam logic [16:0] c_pcload  = 17'h04000;
  localparam logic [16:0] c_pcinc   = 17'h08000;
  localparam logic [16:0] c_pcout   = 17'h10000;
  localparam logic [16:0] c_f0      = c_pcout | c_marin;
  localparam logic [16:0] c_f1      = c_ramout | c_irin | c_pcinc;

  typedef struct {
    logic [3:0]  op;
    logic [1:0]  flags;
    int          len;
    logic [16:0] w2;
    logic [16:0] w3;
    logic [16:0] w4;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  vec_t        tbl [15];
  logic [16:0] prog [16][5];
  int          len_of [16];
  logic [3:0]  op;
  logic [16:0] exp_w;

  control_sequencer_if #(.OPCODE_W(4), .STEP_W(3)) bus ();

  control_sequencer dut (
    .Clock  (clk),
    .ResetN (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [16:0] got_word();
    return {bus.PCOut, bus.PCInc, bus.PCLoad, bus.MARIn, bus.RAMOut, bus.RAMIn,
            bus.IRIn, bus.IROut, bus.AIn, bus.AOut, bus.BIn, bus.ALUOut,
            bus.Operation, bus.FlagsIn, bus.OutIn, bus.Halt};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference microprogram: fetch is common, execute words per opcode.
  task automatic build_prog();
    logic [3:0] alu_ops [4];
    alu_ops = '{4'd2, 4'd3, 4'd9, 4'd10};
    for (int o = 0; o < 16; o++) begin
      len_of[o] = 3;
      for (int k = 0; k < 5; k++) prog[o][k] = 17'd0;
      prog[o][0] = c_f0;
      prog[o][1] = c_f1;
    end
    len_of[1] = 4; prog[1][2] = c_irout | c_marin; prog[1][3] = c_ramout | c_ain;
    len_of[4] = 4; prog[4][2] = c_irout | c_marin; prog[4][3] = c_aout | c_ramin;
    prog[5][2]  = c_irout | c_ain;
    prog[6][2]  = c_irout | c_pcload;
    prog[7][2]  = c_irout | c_pcload;
    prog[8][2]  = c_irout | c_pcload;
    prog[14][2] = c_aout | c_outin;
    for (int i = 0; i < 4; i++) begin
      len_of[alu_ops[i]] = 5;
      prog[alu_ops[i]][2] = c_irout | c_marin;
      prog[alu_ops[i]][3] = c_ramout | c_bin;
      prog[alu_ops[i]][4] = c_aluout | c_ain | c_flagsin | (17'(i) << 3);
    end
  endtask

  function automatic logic [16:0] model(input logic [3:0] o, input int k, input logic [1:0] f);
    logic [16:0] w;
    w = prog[o][k];
    if (k == 2 && ((o == 4'd7 && !f[0]) || (o == 4'd8 && !f[1]))) w = 17'd0;
    return w;
  endfunction

  task automatic run_vec(input int idx);
    logic [16:0] e;
    for (int k = 0; k < tbl[idx].len; k++) begin
      bus.InstrOpcode = tbl[idx].op;
      bus.Flags       = tbl[idx].flags;
      e = (k == 0) ? c_f0 : (k == 1) ? c_f1 : (k == 2) ? tbl[idx].w2 :
          (k == 3) ? tbl[idx].w3 : tbl[idx].w4;
      @(negedge clk);
      check($sformatf("vec%0d_step_t%0d", idx, k), 32'(bus.Step), 32'(k));
      check($sformatf("vec%0d_word_t%0d", idx, k), 32'(got_word()), 32'(e));
      @(posedge clk); #1;
    end
    #3;
    check($sformatf("vec%0d_wrap", idx), 32'(bus.Step), 32'd0);
  endtask

  // Bus exclusivity and step range, every cycle outside reset.
  always @(negedge clk) begin
    if (rst_n) begin
      n_cmp++;
      assert ($countones({bus.PCOut, bus.RAMOut, bus.IROut, bus.AOut, bus.ALUOut}) <= 1)
      else begin
        n_err++;
        $display("FAIL bus_excl: got drivers %b expected at most one",
                 {bus.PCOut, bus.RAMOut, bus.IROut, bus.AOut, bus.ALUOut});
      end
      n_cmp++;
      if (bus.Step > 3'd4) begin
        n_err++;
        $display("FAIL step_range: got %0d expected <= 4", bus.Step);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.InstrOpcode = 4'd0;
    bus.Flags = 2'b00;
    build_prog();

    tbl[0]  = '{4'd1,  2'b00, 4, c_irout | c_marin, c_ramout | c_ain, 17'd0};
    tbl[1]  = '{4'd2,  2'b00, 5, c_irout | c_marin, c_ramout | c_bin, c_aluout | c_ain | c_flagsin};
    tbl[2]  = '{4'd3,  2'b11, 5, c_irout | c_marin, c_ramout | c_bin, c_aluout | c_ain | c_flagsin | 17'h08};
    tbl[3]  = '{4'd9,  2'b00, 5, c_irout | c_marin, c_ramout | c_bin, c_aluout | c_ain | c_flagsin | 17'h10};
    tbl[4]  = '{4'd10, 2'b01, 5, c_irout | c_marin, c_ramout | c_bin, c_aluout | c_ain | c_flagsin | 17'h18};
    tbl[5]  = '{4'd7,  2'b01, 3, c_irout | c_pcload, 17'd0, 17'd0};
    tbl[6]  = '{4'd7,  2'b00, 3, 17'd0, 17'd0, 17'd0};
    tbl[7]  = '{4'd8,  2'b10, 3, c_irout | c_pcload, 17'd0, 17'd0};
    tbl[8]  = '{4'd8,  2'b01, 3, 17'd0, 17'd0, 17'd0};
    tbl[9]  = '{4'd0,  2'b00, 3, 17'd0, 17'd0, 17'd0};
    tbl[10] = '{4'd5,  2'b00, 3, c_irout | c_ain, 17'd0, 17'd0};
    tbl[11] = '{4'd6,  2'b00, 3, c_irout | c_pcload, 17'd0, 17'd0};
    tbl[12] = '{4'd4,  2'b00, 4, c_irout | c_marin, c_aout | c_ramin, 17'd0};
    tbl[13] = '{4'd14, 2'b00, 3, c_aout | c_outin, 17'd0, 17'd0};
    tbl[14] = '{4'd12, 2'b11, 3, 17'd0, 17'd0, 17'd0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_step", 32'(bus.Step), 32'd0);
    check("reset_word", 32'(got_word()), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) run_vec(i);

    // Reset in the middle of ADD's T3 clears outputs without waiting for an edge.
    for (int k = 0; k < 4; k++) begin
      bus.InstrOpcode = 4'd2;
      bus.Flags = 2'b00;
      @(negedge clk);
      check($sformatf("midrst_word_t%0d", k), 32'(got_word()), 32'(prog[2][k]));
      if (k < 3) begin
        @(posedge clk); #1;
      end
    end
    rst_n = 1'b0;
    #1;
    check("midrst_async_step", 32'(bus.Step), 32'd0);
    check("midrst_async_word", 32'(got_word()), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_vec(9);

    // Random instruction stream; opcode is junk during fetch, flags change every cycle.
    for (int n = 0; n < 500; n++) begin
      op = 4'($urandom_range(0, 14));
      for (int k = 0; k < len_of[op]; k++) begin
        bus.InstrOpcode = (k < 2) ? 4'($urandom_range(0, 15)) : op;
        bus.Flags = 2'($urandom);
        exp_w = model(op, k, bus.Flags);
        @(negedge clk);
        check($sformatf("rnd%0d_op%0d_step_t%0d", n, op, k), 32'(bus.Step), 32'(k));
        check($sformatf("rnd%0d_op%0d_word_t%0d", n, op, k), 32'(got_word()), 32'(exp_w));
        @(posedge clk); #1;
      end
    end

    // HLT: sticky halt, step frozen at T2, only reset exits.
    for (int k = 0; k < 3; k++) begin
      bus.InstrOpcode = 4'd15;
      bus.Flags = 2'b00;
      @(negedge clk);
      check($sformatf("hlt_step_t%0d", k), 32'(bus.Step), 32'(k));
      check($sformatf("hlt_word_t%0d", k), 32'(got_word()), 32'((k == 2) ? c_halt : prog[15][k]));
      @(posedge clk); #1;
    end
    for (int c = 0; c < 10; c++) begin
      bus.InstrOpcode = 4'($urandom_range(0, 15));
      bus.Flags = 2'($urandom);
      @(negedge clk);
      check($sformatf("halted%0d_step", c), 32'(bus.Step), 32'd2);
      check($sformatf("halted%0d_word", c), 32'(got_word()), 32'(c_halt));
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    check("hlt_rst_step", 32'(bus.Step), 32'd0);
    check("hlt_rst_word", 32'(got_word()), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.InstrOpcode = 4'd0;
    @(negedge clk);
    check("hlt_exit_step", 32'(bus.Step), 32'd0);
    check("hlt_exit_word", 32'(got_word()), 32'(c_f0));
    @(posedge clk); #1;
    @(negedge clk);
    check("hlt_exit_t1", 32'(bus.Step), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
Microcoded control unit for the 8-bit SAP datapath, sitting directly upstream of the ALU.
- Drives the ALU's Operation and ALUOut inputs, plus every other bus load/drive enable.
- Steps through a fetch/execute T-state sequence using the opcode from the instruction register and the registered ALU flags.
- Variable-length instructions: the step counter returns to T0 after each instruction's last microstep.

Parameters:
OPCODE_W, 4, instruction opcode width (IR high nibble)
STEP_W, 3, step counter width (T0..T4)

Ports:
Clock  input  1  system clock; all state updates on rising edge
ResetN  input  1  asynchronous active-low reset
InstrOpcode  input  4  opcode from instruction register, valid from T2
Flags  input  2  registered ALU flags; bit0 Carry, bit1 Zero
Step  output  3  current T-state, for debug/bench
PCOut, PCInc, PCLoad  output  1 each  program counter drive/increment/load
MARIn  output  1  memory address register load
RAMOut, RAMIn  output  1 each  RAM drive/write
IRIn, IROut  output  1 each  IR load; IR low nibble (operand) onto bus
AIn, AOut, BIn  output  1 each  accumulator load/drive; B register load
ALUOut  output  1  ALU result onto bus
Operation  output  2  ALU op: 0 ADD, 1 SUB, 2 AND, 3 OR
FlagsIn  output  1  flags register load
OutIn  output  1  output register load
Halt  output  1  clock-stop request; sticky

Behaviour:
- Reset (ResetN low, asynchronous): Step=0, halted=0, all control outputs forced 0 while ResetN is low; first fetch begins on the first rising edge after release.
- State: STEP_W-bit step register plus 1-bit halted flag. Outputs are combinational decode of Step, InstrOpcode and Flags; no other logic.
- Fetch, identical for all opcodes:
  - T0: PCOut, MARIn.
  - T1: RAMOut, IRIn, PCInc.
- Execute. Unlisted outputs are 0; Operation defaults to 0. "Last" marks the final step, after which Step returns to 0.
  - NOP (0): T2 none; last.
  - LDA (1): T2 IROut, MARIn; T3 RAMOut, AIn; last.
  - ADD (2), SUB (3), AND (9), OR (10): T2 IROut, MARIn; T3 RAMOut, BIn; T4 ALUOut, AIn, FlagsIn, Operation = 0/1/2/3; last.
  - STA (4): T2 IROut, MARIn; T3 AOut, RAMIn; last.
  - LDI (5): T2 IROut, AIn; last.
  - JMP (6): T2 IROut, PCLoad; last.
  - JC (7): T2 IROut, PCLoad only if Flags[0]=1, else none; last.
  - JZ (8): same as JC, conditioned on Flags[1].
  - OUT (14): T2 AOut, OutIn; last.
  - HLT (15): T2 Halt; halted set on that edge.
  - Undefined (11, 12, 13): treated as NOP.
- Cycle counts: NOP/LDI/JMP/Jx/OUT = 3, LDA/STA = 4, ALU ops = 5.
- Halted: Step frozen at 2, Halt=1, all other outputs 0, opcode/flag changes ignored. Only reset exits.
- Step wrap: Step must never exceed 4; any unreachable value returns to 0 on the next edge.
- Bus exclusivity: at most one of PCOut, RAMOut, IROut, AOut, ALUOut is 1 in any cycle. Assert this in the bench.
- Flags are sampled combinationally at T2 only; a flag change at any other step has no effect.
- Reset mid-instruction: immediate abort; no partial control word survives.

Decomposition:
- Package sap_ctrl_pkg: opcode localparams, ALU op encodings (ADD/SUB/AND/OR), step encodings T0..T4, Flags bit indices (CARRY=0, ZERO=1).
- Sub-module sap_step_counter: step register with synchronous clear (last-step) and hold (halted) inputs, async active-low reset.
- Microcode decode stays in control_sequencer as a single combinational case block.

Test Plan:
- Reset then InstrOpcode=1 (LDA): T0 {PCOut, MARIn}, T1 {RAMOut, IRIn, PCInc}, T2 {IROut, MARIn}, T3 {RAMOut, AIn}; next cycle Step=0.
- InstrOpcode=3 (SUB): T4 shows ALUOut=1, AIn=1, FlagsIn=1, Operation=1; sequence is exactly 5 cycles. Repeat with opcodes 2/9/10 and check Operation 0/2/3.
- JC with Flags=2'b01 -> PCLoad=1 at T2. JC with Flags=2'b00 -> PCLoad=0. Both return to T0 after 3 cycles. JZ with Flags=2'b10 -> PCLoad=1.
- InstrOpcode=15 (HLT): Halt=1 from T2 onward; toggling InstrOpcode/Flags for 10 cycles leaves Step=2, Halt=1, others 0. ResetN pulse -> Step=0, Halt=0.
- ResetN asserted low mid-T3 of ADD: all outputs 0 immediately (before the next edge). After release, T0 fetch resumes.
- Random opcode stream, 500 instructions: bus-exclusivity assertion never fires; Step never exceeds 4.
